// File: rtl/spi_pkg.sv
// Shared constants for the SPI shift controller: spi_mode encodings, FSM state
// encoding and the number of SCLK edges in one transfer.
package spi_pkg;

  localparam logic [1:0] SPI_RUN  = 2'b00;
  localparam logic [1:0] SPI_WAIT = 2'b01;
  localparam logic [1:0] SPI_STOP = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int EDGES_PER_XFER = 16;

  // Half-period in PCLK cycles: (sppr + 1) << spr, range 1..1024.
  function automatic logic [10:0] half_period(input logic [2:0] sppr, input logic [2:0] spr);
    logic [10:0] base;
    base = {8'd0, sppr} + 11'd1;
    return base << spr;
  endfunction

endpackage

// File: rtl/spi_shift_controller_baud.sv
// Baud half-period tick generator: pulses tick for one PCLK cycle every
// (sppr+1)<<spr cycles while enable is high; the counter clears when idle.
module spi_baud_gen
  import spi_pkg::*;
#(
  parameter int CNT_W = 11
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       enable,
  input  logic [2:0] sppr,
  input  logic [2:0] spr,
  output logic       tick
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] half_m1;

  assign half_m1 = CNT_W'(half_period(sppr, spr)) - CNT_W'(1);
  assign tick    = enable && (cnt_reg == half_m1);

  always_ff @(posedge PCLK) begin
    if (PRESET || !enable) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_shift_controller.sv
// Master-side SPI transfer sequencer: one full-duplex DATA_W-bit transfer per
// send_data request. Define SPI_LOOPBACK_EN to sample the registered mosi instead of miso.
module spi_shift_controller
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 11
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              send_data,
  input  logic [DATA_W-1:0] mosi_data,
  input  logic              mstr,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic [2:0]        sppr,
  input  logic [2:0]        spr,
  input  logic [1:0]        spi_mode,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              ss,
  output logic              tip,
  output logic              receive_data,
  output logic [DATA_W-1:0] miso_data
);

  localparam int EDGE_W = $clog2(EDGES_PER_XFER);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(EDGES_PER_XFER - 1);

  logic [1:0]        state_reg;
  logic              sclk_reg;
  logic              mosi_reg;
  logic              ss_reg;
  logic              tip_reg;
  logic              receive_data_reg;
  logic [DATA_W-1:0] miso_data_reg;
  logic [DATA_W-1:0] tx_shift_reg;
  logic [DATA_W-1:0] rx_shift_reg;
  logic [EDGE_W-1:0] edge_cnt_reg;
  logic              cpol_reg;
  logic              cpha_reg;
  logic              lsbfe_reg;
  logic [2:0]        sppr_reg;
  logic [2:0]        spr_reg;

  logic              tick;
  logic              start;
  logic              abort;
  logic              leading;
  logic              last_edge;
  logic              sample_bit;
  logic              do_sample;
  logic              do_present;
  logic [DATA_W-1:0] mosi_data_rev;
  logic [DATA_W-1:0] rx_rev;
  logic [DATA_W-1:0] tx_load;

  spi_baud_gen #(
    .CNT_W (CNT_W)
  ) u_baud (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .enable (state_reg == ST_SHIFT),
    .sppr   (sppr_reg),
    .spr    (spr_reg),
    .tick   (tick)
  );

  // Both shift registers always move MSB-first; LSB-first is handled by bit
  // reversal on load and on delivery, so one datapath serves both orders.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_rev
      assign mosi_data_rev[gi] = mosi_data[DATA_W-1-gi];
      assign rx_rev[gi]        = rx_shift_reg[DATA_W-1-gi];
    end
  endgenerate

  assign tx_load = lsbfe ? mosi_data_rev : mosi_data;

  assign start     = send_data && mstr && (spi_mode == SPI_RUN);
  assign abort     = (spi_mode == SPI_STOP) || !mstr;
  assign leading   = ~edge_cnt_reg[0];
  assign last_edge = (edge_cnt_reg == LAST_EDGE);

`ifdef SPI_LOOPBACK_EN
  assign sample_bit = mosi_reg;
`else
  assign sample_bit = miso;
`endif

  // cpha=0 samples on leading edges and presents on trailing edges; cpha=1 the reverse.
  assign do_sample  = (leading != cpha_reg);
  assign do_present = cpha_reg ? leading : (!leading && !last_edge);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_reg        <= ST_IDLE;
      sclk_reg         <= 1'b0;
      mosi_reg         <= 1'b0;
      ss_reg           <= 1'b1;
      tip_reg          <= 1'b0;
      receive_data_reg <= 1'b0;
      miso_data_reg    <= '0;
      tx_shift_reg     <= '0;
      rx_shift_reg     <= '0;
      edge_cnt_reg     <= '0;
      cpol_reg         <= 1'b0;
      cpha_reg         <= 1'b0;
      lsbfe_reg        <= 1'b0;
      sppr_reg         <= '0;
      spr_reg          <= '0;
    end else begin
      receive_data_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          sclk_reg <= cpol;
          ss_reg   <= 1'b1;
          tip_reg  <= 1'b0;
          if (start) begin
            state_reg    <= ST_SHIFT;
            ss_reg       <= 1'b0;
            tip_reg      <= 1'b1;
            cpol_reg     <= cpol;
            cpha_reg     <= cpha;
            lsbfe_reg    <= lsbfe;
            sppr_reg     <= sppr;
            spr_reg      <= spr;
            edge_cnt_reg <= '0;
            rx_shift_reg <= '0;
            mosi_reg     <= tx_load[DATA_W-1];
            tx_shift_reg <= cpha ? tx_load : {tx_load[DATA_W-2:0], 1'b0};
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state_reg <= ST_IDLE;
            sclk_reg  <= cpol_reg;
            ss_reg    <= 1'b1;
            tip_reg   <= 1'b0;
          end else if (tick) begin
            sclk_reg     <= ~sclk_reg;
            edge_cnt_reg <= edge_cnt_reg + EDGE_W'(1);
            if (do_sample) begin
              rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], sample_bit};
            end
            if (do_present) begin
              mosi_reg     <= tx_shift_reg[DATA_W-1];
              tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
            end
            if (last_edge) begin
              state_reg <= ST_DONE;
              ss_reg    <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          miso_data_reg    <= lsbfe_reg ? rx_rev : rx_shift_reg;
          receive_data_reg <= 1'b1;
          ss_reg           <= 1'b1;
          tip_reg          <= 1'b0;
          state_reg        <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign sclk         = sclk_reg;
  assign mosi         = mosi_reg;
  assign ss           = ss_reg;
  assign tip          = tip_reg;
  assign receive_data = receive_data_reg;
  assign miso_data    = miso_data_reg;

endmodule

// File: tb/tb_spi_shift_controller.sv
// Self-checking bench for spi_shift_controller: a behavioural SPI slave plus
// expected byte/timing model built from bit order and half-period arithmetic.
module tb_spi_shift_controller;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       send_data;
  logic [7:0] mosi_data;
  logic       mstr;
  logic       cpol;
  logic       cpha;
  logic       lsbfe;
  logic [2:0] sppr;
  logic [2:0] spr;
  logic [1:0] spi_mode;
  logic       miso;
  logic       sclk;
  logic       mosi;
  logic       ss;
  logic       tip;
  logic       receive_data;
  logic [7:0] miso_data;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_rx;

`ifdef SPI_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  always #5 PCLK = ~PCLK;

  spi_shift_controller dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .send_data    (send_data),
    .mosi_data    (mosi_data),
    .mstr         (mstr),
    .cpol         (cpol),
    .cpha         (cpha),
    .lsbfe        (lsbfe),
    .sppr         (sppr),
    .spr          (spr),
    .spi_mode     (spi_mode),
    .miso         (miso),
    .sclk         (sclk),
    .mosi         (mosi),
    .ss           (ss),
    .tip          (tip),
    .receive_data (receive_data),
    .miso_data    (miso_data)
  );

  // k-th bit on the wire for a byte in the given order
  function automatic logic bit_of(input logic [7:0] b, input int k, input logic lsb);
    return lsb ? b[k] : b[7-k];
  endfunction

  function automatic int half_of(input logic [2:0] pp, input logic [2:0] sp);
    return (int'(pp) + 1) * (1 << int'(sp));
  endfunction

  task automatic do_xfer(input logic [7:0] tx, input logic [7:0] slave, input logic c_pol,
                         input logic c_pha, input logic lsb, input logic [2:0] pp,
                         input logic [2:0] sp, input string tag);
    int h, edges, last_edge_idx, tip_cnt, ss_cnt, rd_cnt, phase_err, k;
    logic prev_sclk;
    logic [7:0] got_mosi, rd_val, exp_rx;
    h = half_of(pp, sp);
    exp_rx = LOOPBACK ? tx : slave;
    cpol = c_pol; cpha = c_pha; lsbfe = lsb; sppr = pp; spr = sp;
    mstr = 1'b1; spi_mode = 2'b00; mosi_data = tx; send_data = 1'b0;
    miso = bit_of(slave, 0, lsb);
    @(negedge PCLK);
    checks++;
    if (sclk !== c_pol || ss !== 1'b1 || tip !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: sclk=%b ss=%b tip=%b required sclk=%b ss=1 tip=0", tag, sclk, ss, tip, c_pol);
    end
    send_data = 1'b1;
    @(negedge PCLK);
    send_data = 1'b0;
    prev_sclk = c_pol; edges = 0; last_edge_idx = 0; tip_cnt = 0; ss_cnt = 0;
    rd_cnt = 0; phase_err = 0; got_mosi = ~tx; rd_val = 8'hxx;
    for (int idx = 0; idx < 16 * h + 4; idx++) begin
      if (tip === 1'b1) tip_cnt++;
      if (ss === 1'b0) ss_cnt++;
      if (receive_data === 1'b1) begin
        rd_cnt++;
        rd_val = miso_data;
      end
      if (sclk !== prev_sclk) begin
        edges++;
        if (idx - last_edge_idx != h) phase_err++;
        last_edge_idx = idx;
        if (((edges % 2) == 1) != c_pha) begin
          k = c_pha ? edges / 2 - 1 : (edges - 1) / 2;
          if (k >= 0 && k < 8) got_mosi[lsb ? k : 7 - k] = mosi;
        end else if (edges < 16) begin
          k = c_pha ? (edges - 1) / 2 : edges / 2;
          if (k < 8) miso = bit_of(slave, k, lsb);
        end
        prev_sclk = sclk;
      end
      @(negedge PCLK);
    end
    checks++;
    if (edges != 16 || phase_err != 0) begin
      errors++;
      $display("FAIL %s sclk_edges: edges=%0d bad_phases=%0d required edges=16 phase=%0d", tag, edges, phase_err, h);
    end
    checks++;
    if (got_mosi !== tx) begin
      errors++;
      $display("FAIL %s mosi_bits: got %h required %h", tag, got_mosi, tx);
    end
    checks++;
    if (tip_cnt != 16 * h + 1 || ss_cnt != 16 * h) begin
      errors++;
      $display("FAIL %s tip_ss_len: tip=%0d ss_low=%0d required tip=%0d ss_low=%0d", tag, tip_cnt, ss_cnt, 16 * h + 1, 16 * h);
    end
    checks++;
    if (rd_cnt != 1 || rd_val !== exp_rx) begin
      errors++;
      $display("FAIL %s receive: pulses=%0d data=%h required pulses=1 data=%h", tag, rd_cnt, rd_val, exp_rx);
    end
    checks++;
    if (miso_data !== exp_rx || sclk !== c_pol || tip !== 1'b0 || ss !== 1'b1) begin
      errors++;
      $display("FAIL %s final: miso_data=%h sclk=%b tip=%b ss=%b required %h %b 0 1", tag, miso_data, sclk, tip, ss, exp_rx, c_pol);
    end
    last_rx = exp_rx;
    $display("xfer %s: tx=%h slave=%h cpol=%b cpha=%b lsbfe=%b H=%0d rx=%h", tag, tx, slave, c_pol, c_pha, lsb, h, miso_data);
  endtask

  task automatic test_reset();
    PRESET = 1'b1; send_data = 1'b0; mosi_data = 8'h00; mstr = 1'b0; cpol = 1'b1;
    cpha = 1'b0; lsbfe = 1'b0; sppr = 3'd0; spr = 3'd0; spi_mode = 2'b00; miso = 1'b0;
    repeat (3) @(negedge PCLK);
    checks++;
    if (sclk !== 1'b0 || mosi !== 1'b0 || ss !== 1'b1 || tip !== 1'b0 || receive_data !== 1'b0 || miso_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: sclk=%b mosi=%b ss=%b tip=%b rd=%b miso_data=%h required 0 0 1 0 0 00",
               sclk, mosi, ss, tip, receive_data, miso_data);
    end
    PRESET = 1'b0;
    @(negedge PCLK);
    checks++;
    if (sclk !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_sclk: sclk=%b required 1", sclk);
    end
    last_rx = 8'h00;
    $display("xfer reset: outputs at reset values, idle sclk follows cpol");
  endtask

  task automatic test_mode0();
    do_xfer(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, "mode0_h1");
  endtask

  task automatic test_mode3();
    do_xfer(8'h81, 8'h42, 1'b1, 1'b1, 1'b1, 3'd2, 3'd1, "mode3_h6");
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      do_xfer(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_max_divisor();
    do_xfer(8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0, 3'd7, 3'd7, "h1024");
  endtask

  task automatic test_abort();
    int edges, rd_cnt;
    logic prev_sclk;
    cpol = 1'b1; cpha = 1'b0; lsbfe = 1'b0; sppr = 3'd1; spr = 3'd0;
    mstr = 1'b1; spi_mode = 2'b00; mosi_data = 8'($urandom); miso = 1'b1;
    @(negedge PCLK);
    send_data = 1'b1;
    @(negedge PCLK);
    send_data = 1'b0;
    edges = 0; prev_sclk = 1'b1;
    for (int i = 0; i < 100 && edges < 5; i++) begin
      @(negedge PCLK);
      if (sclk !== prev_sclk) begin
        edges++;
        prev_sclk = sclk;
      end
    end
    checks++;
    if (edges != 5) begin
      errors++;
      $display("FAIL abort_reach_edge5: edges=%0d required 5", edges);
    end
    spi_mode = 2'b10;
    @(negedge PCLK);
    checks++;
    if (ss !== 1'b1 || tip !== 1'b0 || sclk !== 1'b1) begin
      errors++;
      $display("FAIL abort_outputs: ss=%b tip=%b sclk=%b required 1 0 1", ss, tip, sclk);
    end
    spi_mode = 2'b00;
    rd_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (receive_data === 1'b1) rd_cnt++;
      @(negedge PCLK);
    end
    checks++;
    if (rd_cnt != 0 || miso_data !== last_rx) begin
      errors++;
      $display("FAIL abort_no_receive: pulses=%0d miso_data=%h required 0 %h", rd_cnt, miso_data, last_rx);
    end
    $display("xfer abort: stop after edge 5, miso_data kept %h", miso_data);
  endtask

  task automatic test_mstr_gate();
    int bad, rd_cnt;
    logic [7:0] tx, exp_rx;
    tx = 8'($urandom);
    exp_rx = LOOPBACK ? tx : 8'h00;
    cpol = 1'b1; cpha = 1'b1; lsbfe = 1'b0; sppr = 3'd0; spr = 3'd0;
    spi_mode = 2'b00; miso = 1'b0; mosi_data = tx;
    mstr = 1'b0; send_data = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      if (ss !== 1'b1 || tip !== 1'b0 || sclk !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mstr_gate_idle: %0d active cycles required 0", bad);
    end
    mstr = 1'b1;
    @(negedge PCLK);
    send_data = 1'b0;
    checks++;
    if (tip !== 1'b1 || ss !== 1'b0) begin
      errors++;
      $display("FAIL mstr_gate_start: tip=%b ss=%b required 1 0", tip, ss);
    end
    rd_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      if (receive_data === 1'b1) rd_cnt++;
      @(negedge PCLK);
    end
    checks++;
    if (rd_cnt != 1 || miso_data !== exp_rx) begin
      errors++;
      $display("FAIL mstr_gate_done: pulses=%0d miso_data=%h required 1 %h", rd_cnt, miso_data, exp_rx);
    end
    last_rx = exp_rx;
    $display("xfer mstr_gate: tx=%h rx=%h", tx, miso_data);
  endtask

  task automatic test_reset_mid();
    cpol = 1'b1; cpha = 1'b0; lsbfe = 1'b1; sppr = 3'd2; spr = 3'd0;
    mstr = 1'b1; spi_mode = 2'b00; mosi_data = 8'hFF; miso = 1'b1;
    @(negedge PCLK);
    send_data = 1'b1;
    @(negedge PCLK);
    send_data = 1'b0;
    repeat (20) @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    checks++;
    if (sclk !== 1'b0 || mosi !== 1'b0 || ss !== 1'b1 || tip !== 1'b0 || receive_data !== 1'b0 || miso_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_shift: sclk=%b mosi=%b ss=%b tip=%b rd=%b miso_data=%h required 0 0 1 0 0 00",
               sclk, mosi, ss, tip, receive_data, miso_data);
    end
    PRESET = 1'b0;
    last_rx = 8'h00;
    $display("xfer reset_mid: outputs at reset values");
    do_xfer(8'h5A, 8'($urandom), 1'b0, 1'b0, 1'b0, 3'd1, 3'd1, "after_reset");
  endtask

  task automatic test_back_to_back();
    int hi1, gap, phase;
    logic [7:0] tx;
    tx = 8'($urandom);
    cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; sppr = 3'd0; spr = 3'd0;
    mstr = 1'b1; spi_mode = 2'b00; mosi_data = tx; miso = 1'b0;
    @(negedge PCLK);
    send_data = 1'b1;
    @(negedge PCLK);
    hi1 = 0; gap = 0; phase = 0;
    for (int i = 0; i < 60; i++) begin
      if (phase == 0) begin
        if (tip === 1'b1) hi1++;
        else begin
          phase = 1;
          gap = 1;
        end
      end else if (phase == 1) begin
        if (tip === 1'b0) gap++;
        else phase = 2;
      end
      @(negedge PCLK);
    end
    send_data = 1'b0;
    repeat (40) @(negedge PCLK);
    checks++;
    if (hi1 != 17 || phase != 2 || gap != 1) begin
      errors++;
      $display("FAIL back_to_back: tip_high=%0d restarted=%0d gap=%0d required 17 1 1", hi1, phase == 2, gap);
    end
    checks++;
    if (miso_data !== (LOOPBACK ? tx : 8'h00)) begin
      errors++;
      $display("FAIL back_to_back_data: miso_data=%h required %h", miso_data, LOOPBACK ? tx : 8'h00);
    end
    last_rx = miso_data;
    $display("xfer back_to_back: tip_high=%0d gap=%0d", hi1, gap);
  endtask

  task automatic test_loopback_byte();
    do_xfer(8'hC3, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1, "c3_miso0");
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_abort();
    test_mstr_gate();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_loopback_byte();
    test_max_divisor();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
